// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and external-memory signals of the shared memory port.
// The slave modport is the arbiter's view; the master modport is the requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              i_stall;
  logic              d_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              omem_re;
  logic              omem_wr;
  logic              mem_ready;
  logic [DATA_W-1:0] data_out;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_ready, data_out,
    output if_valid, if_rdata, d_valid, d_rdata, i_stall, d_stall,
           mem_addr, mem_wdata, omem_re, omem_wr
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_ready, data_out,
    input  if_valid, if_rdata, d_valid, d_rdata, i_stall, d_stall,
           mem_addr, mem_wdata, omem_re, omem_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch and load/store; data wins, fetch starvation bounded.
// Enables assert the cycle after the grant edge; valid pulses in the first mem_ready cycle; one IDLE cycle between accesses.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, IFETCH, DACCESS, DRAIN} state_t;

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              if_done, d_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    if_done = 1'b0;
    d_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // Fetch only overrides data once it has watched CNT_MAX data grants go by.
        if (bus.d_req && !(bus.if_req && cnt_q == CNT_MAX)) begin
          state_d = DACCESS;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          we_d    = bus.d_we;
          cnt_d   = bus.if_req ? cnt_q + 4'd1 : 4'd0;
        end else if (bus.if_req) begin
          state_d = IFETCH;
          addr_d  = bus.if_addr;
          cnt_d   = 4'd0;
        end
      end
      IFETCH: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
          if_done = !bus.if_flush;
        end else if (bus.if_flush) begin
          state_d = DRAIN;
        end
      end
      DACCESS: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
          d_done  = 1'b1;
        end
      end
      DRAIN: begin
        if (bus.mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Everything is gated by rst so the pins go quiet the instant reset asserts.
  assign bus.omem_re   = rst && (state_q == IFETCH || state_q == DRAIN || (state_q == DACCESS && !we_q));
  assign bus.omem_wr   = rst && state_q == DACCESS && we_q;
  assign bus.mem_addr  = (rst && state_q != IDLE) ? addr_q  : '0;
  assign bus.mem_wdata = (rst && state_q != IDLE) ? wdata_q : '0;

  assign bus.if_valid  = rst && if_done;
  assign bus.if_rdata  = (rst && if_done) ? bus.data_out : '0;
  assign bus.d_valid   = rst && d_done;
  assign bus.d_rdata   = (rst && d_done && !we_q) ? bus.data_out : '0;
  assign bus.i_stall   = rst && bus.if_req && !if_done;
  assign bus.d_stall   = rst && bus.d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model is checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what transaction (if any) owns the port, plus the fetch-starvation tally.
  typedef enum {T_NONE, T_FETCH, T_DATA, T_DRAIN} txn_t;
  txn_t          m_txn;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  int            m_starve;
  string         grant_log;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_txn    <= T_NONE;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_we     <= 1'b0;
      m_starve <= 0;
    end else begin
      case (m_txn)
        T_NONE: begin
          if (bus.d_req && !(bus.if_req && m_starve >= SM)) begin
            m_txn    <= T_DATA;
            m_addr   <= bus.d_addr;
            m_wdata  <= bus.d_wdata;
            m_we     <= bus.d_we;
            m_starve <= bus.if_req ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
            grant_log = {grant_log, "D"};
          end else if (bus.if_req) begin
            m_txn    <= T_FETCH;
            m_addr   <= bus.if_addr;
            m_starve <= 0;
            grant_log = {grant_log, "I"};
          end
        end
        T_FETCH: if (bus.mem_ready) m_txn <= T_NONE; else if (bus.if_flush) m_txn <= T_DRAIN;
        default: if (bus.mem_ready) m_txn <= T_NONE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic          e_re, e_wr, e_iv, e_dv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_ird, e_drd;
    e_re   = rst && (m_txn == T_FETCH || m_txn == T_DRAIN || (m_txn == T_DATA && !m_we));
    e_wr   = rst && m_txn == T_DATA && m_we;
    e_addr = (rst && m_txn != T_NONE) ? m_addr : '0;
    e_iv   = rst && m_txn == T_FETCH && bus.mem_ready && !bus.if_flush;
    e_dv   = rst && m_txn == T_DATA && bus.mem_ready;
    e_ird  = e_iv ? bus.data_out : '0;
    e_drd  = (e_dv && !m_we) ? bus.data_out : '0;
    chk("cyc omem_re",  bus.omem_re,  e_re);
    chk("cyc omem_wr",  bus.omem_wr,  e_wr);
    chk("cyc mem_addr", bus.mem_addr, e_addr);
    if (e_wr || m_txn == T_NONE || !rst)
      chk("cyc mem_wdata", bus.mem_wdata, e_wr ? m_wdata : '0);
    chk("cyc if_valid", bus.if_valid, e_iv);
    chk("cyc if_rdata", bus.if_rdata, e_ird);
    chk("cyc d_valid",  bus.d_valid,  e_dv);
    chk("cyc d_rdata",  bus.d_rdata,  e_drd);
    chk("cyc i_stall",  bus.i_stall,  rst && bus.if_req && !e_iv);
    chk("cyc d_stall",  bus.d_stall,  rst && bus.d_req && !e_dv);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0;
    bus.if_flush  = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;
    bus.mem_ready = 1'b0;
    bus.data_out  = 32'h0;
    grant_log     = "";
    repeat (2) @(posedge clk);
    #1;
    chk("reset i_stall", bus.i_stall, 1'b0);
    chk("reset omem_re", bus.omem_re, 1'b0);
    bus.if_req = 1'b0;
    rst = 1'b1;
    tick();

    // 1: fetch only, memory answers on the 3rd enabled cycle
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    chk("t1 omem_re", bus.omem_re, 1'b1);
    chk("t1 mem_addr", bus.mem_addr, 32'h100);
    tick(); tick();
    bus.mem_ready = 1'b1; bus.data_out = 32'h00500093;
    #1;
    chk("t1 if_valid", bus.if_valid, 1'b1);
    chk("t1 if_rdata", bus.if_rdata, 32'h00500093);
    tick();
    bus.if_req = 1'b0; bus.mem_ready = 1'b0; bus.data_out = 32'h0;
    chk("t1 re after", bus.omem_re, 1'b0);
    tick();

    // 2: simultaneous write + fetch, data first
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    tick();
    chk("t2 omem_wr", bus.omem_wr, 1'b1);
    chk("t2 mem_addr", bus.mem_addr, 32'h2000);
    chk("t2 mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    bus.mem_ready = 1'b1;
    #1;
    chk("t2 d_valid", bus.d_valid, 1'b1);
    tick();
    bus.d_req = 1'b0; bus.mem_ready = 1'b0;
    chk("t2 idle gap re", bus.omem_re, 1'b0);
    tick();
    chk("t2 fetch re", bus.omem_re, 1'b1);
    chk("t2 fetch addr", bus.mem_addr, 32'h104);
    bus.mem_ready = 1'b1;
    tick();
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    tick();

    // 3: starvation bound with both requests held, memory always ready
    grant_log = "";
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.mem_ready = 1'b1; bus.data_out = 32'h11223344;
    repeat (12) tick();
    bus.d_req = 1'b0; bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    checks++;
    if (grant_log != "DDIDDI") begin
      errors++;
      $display("FAIL t3 grant order: got %s expected DDIDDI", grant_log);
    end
    tick();

    // 4: flush while memory is busy drains the fetch, then a new fetch runs
    bus.if_req = 1'b1; bus.if_addr = 32'h108;
    tick();
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush = 1'b0; bus.if_addr = 32'h200;
    chk("t4 drain re", bus.omem_re, 1'b1);
    chk("t4 drain addr", bus.mem_addr, 32'h108);
    tick();
    bus.mem_ready = 1'b1; bus.data_out = 32'h0BAD0BAD;
    #1;
    chk("t4 drain no valid", bus.if_valid, 1'b0);
    tick();
    bus.mem_ready = 1'b0;
    tick();
    chk("t4 new addr", bus.mem_addr, 32'h200);
    bus.mem_ready = 1'b1; bus.data_out = 32'h00000013;
    #1;
    chk("t4 new valid", bus.if_valid, 1'b1);
    chk("t4 new rdata", bus.if_rdata, 32'h00000013);
    tick();
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    tick();

    // 5: flush in the same cycle memory completes, then a load
    bus.if_req = 1'b1; bus.if_addr = 32'h10C;
    tick();
    bus.if_flush = 1'b1; bus.mem_ready = 1'b1; bus.data_out = 32'h55;
    #1;
    chk("t5 flushed valid", bus.if_valid, 1'b0);
    tick();
    bus.if_flush = 1'b0; bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000;
    chk("t5 idle re", bus.omem_re, 1'b0);
    tick();
    bus.mem_ready = 1'b1; bus.data_out = 32'hCAFEF00D;
    #1;
    chk("t5 d_valid", bus.d_valid, 1'b1);
    chk("t5 d_rdata", bus.d_rdata, 32'hCAFEF00D);
    tick();
    bus.d_req = 1'b0; bus.mem_ready = 1'b0;
    tick();

    // 6: async reset mid-write, then counter must restart from zero
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h4000; bus.d_wdata = 32'h1234;
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    tick();
    chk("t6 omem_wr pre", bus.omem_wr, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6 omem_wr async", bus.omem_wr, 1'b0);
    chk("t6 mem_addr async", bus.mem_addr, 32'h0);
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      #1;
      chk("t6 idle if_valid", bus.if_valid, 1'b0);
      chk("t6 idle d_valid", bus.d_valid, 1'b0);
      tick();
    end
    grant_log = "";
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.if_req = 1'b1;
    repeat (6) tick();
    bus.d_req = 1'b0; bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    checks++;
    if (grant_log != "DDI") begin
      errors++;
      $display("FAIL t6 post-reset order: got %s expected DDI", grant_log);
    end
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single external memory port between the fetch stage (instruction reads) and the load/store path (data reads/writes).
- Sequences each access with the external `mem_ready` handshake.
- Gives data priority over fetch, with a bounded-starvation guarantee for fetch.
- Supports cancelling an in-flight fetch when a jump is taken.
- Sits between fetch/decode and the top-level memory pins; drives `addr`, `data_in`, `omem_re` and `omem_wr`.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending; range 1..15

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request; held high until if_valid
- if_addr  input  ADDR_W  fetch address; stable while if_req is high
- if_flush  input  1  cancel the outstanding fetch (jump taken)
- if_valid  output  1  fetch complete, one-cycle pulse
- if_rdata  output  DATA_W  fetched instruction; 0 when if_valid=0
- d_req  input  1  data request; held high until d_valid
- d_we  input  1  1 = write, 0 = read
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_valid  output  1  data access complete, one-cycle pulse
- d_rdata  output  DATA_W  load data; 0 unless d_valid is high and the access is a read
- i_stall  output  1  if_req & ~if_valid
- d_stall  output  1  d_req & ~d_valid
- mem_addr  output  ADDR_W  external address
- mem_wdata  output  DATA_W  external write data
- omem_re  output  1  external read enable
- omem_wr  output  1  external write enable
- mem_ready  input  1  external access complete in this cycle
- data_out  input  DATA_W  external read data; valid when mem_ready is high

Behaviour:
- **States:** IDLE, IFETCH, DACCESS, DRAIN.
- **Reset** (rst=0, takes effect asynchronously):
  - state=IDLE, starve counter=0, latched address/wdata/we=0.
  - All outputs 0.
  - A reset mid-access aborts it immediately; omem_re and omem_wr drop without waiting for a clock.
- **IDLE arbitration**, evaluated at each clock edge:
  - If d_req && !(if_req && cnt==STARVE_MAX): go to DACCESS. Latch d_addr, d_wdata, d_we. If if_req is high, cnt++; otherwise cnt=0.
  - Else if if_req: go to IFETCH. Latch if_addr. cnt=0.
  - Else stay in IDLE.
  - if_flush is ignored in IDLE.
- **Outputs** (decoded from state and latched registers, no combinational path from requests):
  - omem_re = (IFETCH | DRAIN | (DACCESS & !we_q)).
  - omem_wr = DACCESS & we_q.
  - mem_addr and mem_wdata come from the latched registers; they are 0 in IDLE.
- **Completion** (combinational in the cycle mem_ready is high):
  - IFETCH & mem_ready & !if_flush: if_valid=1, if_rdata=data_out.
  - DACCESS & mem_ready: d_valid=1; d_rdata=data_out for reads only.
  - After any completion, the next state is IDLE.
  - Requesters may deassert or change their request in the cycle after valid.
  - There is a minimum of one IDLE cycle between accesses. Access latency is grant edge → enables asserted next cycle → valid in the first cycle mem_ready is high.
- **Flush:**
  - IFETCH & if_flush & !mem_ready: go to DRAIN. omem_re and mem_addr are held until mem_ready, with no if_valid. DRAIN & mem_ready goes to IDLE.
  - IFETCH & if_flush & mem_ready: no if_valid; go to IDLE.
  - if_flush during DACCESS or DRAIN: no effect. Data accesses are never cancelled.
- **mem_ready in IDLE** is ignored.
- **Request handling:**
  - Requests are level-sensitive.
  - A request dropped mid-access does not abort the external transaction; a data access still completes, and its d_valid pulse still occurs.
- **Starve counter:**
  - Saturates at STARVE_MAX.
  - Counts only data grants made while if_req is high.
  - Cleared on a fetch grant, and on a data grant with if_req low.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x100; mem_ready asserted 3 cycles after omem_re, with data_out=0x00500093 → omem_re=1 and mem_addr=0x100 from grant+1; single if_valid pulse with if_rdata=0x00500093; omem_re=0 the next cycle.
2. Simultaneous requests: d_req write to 0x2000 with d_wdata=0xDEADBEEF, plus if_req to 0x104, same cycle → omem_wr=1, mem_addr=0x2000, mem_wdata=0xDEADBEEF first; after d_valid, one IDLE cycle, then omem_re=1 with mem_addr=0x104.
3. Starvation with STARVE_MAX=2: d_req and if_req both held continuously, mem_ready always 1 → grant sequence D,D,I,D,D,I; i_stall deasserts exactly on the if_valid cycles.
4. Flush mid-fetch: fetch 0x108 granted, if_flush=1 while mem_ready=0 → DRAIN; omem_re stays 1 with mem_addr=0x108; no if_valid on the mem_ready cycle; then new fetch to 0x200 granted and completes normally.
5. Flush coincident with mem_ready in IFETCH → if_valid stays 0 and state returns to IDLE; a following load from 0x3000 returns d_rdata=data_out with d_valid=1.
6. Reset mid-write: rst=0 asserted between clock edges during DACCESS → omem_wr=0 immediately; after rst=1, state is IDLE and cnt=0; mem_ready=1 while IDLE produces no valid pulses.
